alu_share_arbiter: RTL and testbench

- Shares one combinational ALU instance between NREQ requesters, e.g. the core execute path and a debug/CSR helper.
- Requesters present operands and an ALU select code with a valid/ready handshake.
- A round-robin arbiter grants one request per cycle and drives the ALU. The result is captured in a one-entry response register tagged with the requester id.
- Responses use valid/ready with full backpressure. The block sits between the requesters and the ALU, which is instantiated outside this block.

---
 rtl/alu_share_arbiter_if.sv | 76 +++++++
 rtl/alu_share_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
//
// Bundle of every signal that crosses the alu_share_arbiter boundary apart
// from clock and reset.
//
//   req_valid   [NREQ]       per-requester request valid
//   req_ready   [NREQ]       per-requester accept (one-hot or zero)
//   req_a       [32*NREQ]    operand A, requester i at [32i+31:32i]
//   req_b       [32*NREQ]    operand B, same packing as req_a
//   req_sel     [5*NREQ]     ALU select, requester i at [5i+4:5i]
//   alu_a/alu_b [32]         operands driven to the external shared ALU
//   alu_sel     [5]          select driven to the external shared ALU
//   alu_result  [32]         combinational result from the external ALU
//   resp_valid  [1]          response register holds a result
//   resp_ready  [1]          consumer takes the response
//   resp_id     [IDW]        requester that issued the response
//   resp_result [32]         registered ALU result
//
// slave  : the arbiter's view.
// master : the surrounding system (requesters, ALU and response consumer).
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [5*NREQ-1:0]  req_sel;

  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic [4:0]         alu_sel;
  logic [31:0]        alu_result;

  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_result;

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_sel,
    input  alu_result,
    input  resp_ready,
    output req_ready,
    output alu_a,
    output alu_b,
    output alu_sel,
    output resp_valid,
    output resp_id,
    output resp_result
  );

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_sel,
    output alu_result,
    output resp_ready,
    input  req_ready,
    input  alu_a,
    input  alu_b,
    input  alu_sel,
    input  resp_valid,
    input  resp_id,
    input  resp_result
  );

endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external combinational ALU between NREQ requesters. A
// round-robin arbiter picks at most one request per cycle, steers its
// operands and select code onto the ALU, and captures the ALU result into a
// single response register tagged with the winning requester's index.
// The response side is valid/ready with full backpressure: nothing is
// granted while an unconsumed response sits in the register, and a consume
// and a new accept may happen in the same cycle with no bubble.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_share_arbiter_if.slave (request, ALU and response signals)
//
// Parameters:
//   NREQ   number of requesters, 2..4
//   IDW    width of requester id, 2**IDW >= NREQ
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input logic               clk,
  input logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  localparam int             DATA_W  = 32;
  localparam int             SEL_W   = 5;
  // Lookup tables are sized to the full id space so an IDW-bit id indexes
  // them exactly; slots at or above NREQ are tied off as never valid.
  localparam int             NSLOT   = 2**IDW;
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  logic [NSLOT-1:0]  vld_vec;
  logic [DATA_W-1:0] a_arr   [NSLOT];
  logic [DATA_W-1:0] b_arr   [NSLOT];
  logic [SEL_W-1:0]  sel_arr [NSLOT];

  logic              slot_free;
  logic              grant_vld;
  logic [IDW-1:0]    grant_id;
  logic [IDW-1:0]    cand;
  logic              accept;
  logic [IDW-1:0]    next_ptr;

  logic              resp_valid_q, resp_valid_d;
  logic [IDW-1:0]    resp_id_q,    resp_id_d;
  logic [DATA_W-1:0] resp_result_q, resp_result_d;
  logic [IDW-1:0]    rr_ptr_q,     rr_ptr_d;

  // Unpack the flat request buses into per-requester slots.
  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < NREQ) begin : g_live
      assign vld_vec[g] = bus.req_valid[g];
      assign a_arr[g]   = bus.req_a[DATA_W*g +: DATA_W];
      assign b_arr[g]   = bus.req_b[DATA_W*g +: DATA_W];
      assign sel_arr[g] = bus.req_sel[SEL_W*g +: SEL_W];
    end else begin : g_pad
      assign vld_vec[g] = 1'b0;
      assign a_arr[g]   = '0;
      assign b_arr[g]   = '0;
      assign sel_arr[g] = '0;
    end
  end

  // Round-robin search: start at rr_ptr, walk upward with wrap at NREQ-1,
  // first valid requester wins. Held off in reset and while the response
  // register is occupied and not being drained.
  always_comb begin
    slot_free = !resp_valid_q || bus.resp_ready;
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = rr_ptr_q;
    if (rst_n && slot_free) begin
      for (int off = 0; off < NREQ; off++) begin
        if (!grant_vld && vld_vec[cand]) begin
          grant_vld = 1'b1;
          grant_id  = cand;
        end
        cand = (cand == LAST_ID) ? '0 : cand + IDW'(1);
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_ready
    assign bus.req_ready[g] = grant_vld && (grant_id == IDW'(g));
  end

  // Idle ALU inputs are zero (select 0 = add); the result is then ignored.
  assign bus.alu_a   = grant_vld ? a_arr[grant_id]   : '0;
  assign bus.alu_b   = grant_vld ? b_arr[grant_id]   : '0;
  assign bus.alu_sel = grant_vld ? sel_arr[grant_id] : '0;

  assign accept   = grant_vld && vld_vec[grant_id];
  assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);

  // An accept both fills the register and (if it was full) replaces the
  // consumed entry; a consume alone only clears valid so id/result hold.
  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    rr_ptr_d      = rr_ptr_q;
    if (accept) begin
      resp_valid_d  = 1'b1;
      resp_id_d     = grant_id;
      resp_result_d = bus.alu_result;
      rr_ptr_d      = next_ptr;
    end else if (bus.resp_ready) begin
      resp_valid_d  = 1'b0;
    end
  end

  // ---- stage boundary: response register and round-robin pointer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      rr_ptr_q      <= '0;
    end else begin
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // External ALU model (RISC-V style {funct7[5], funct3} encoding).
  logic signed [31:0] alu_sa;
  always_comb begin
    alu_sa = bus.alu_a;
    case (bus.alu_sel)
      5'b00000: bus.alu_result = bus.alu_a + bus.alu_b;
      5'b00001: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      5'b00010: bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      5'b00011: bus.alu_result = {31'd0, bus.alu_a < bus.alu_b};
      5'b00100: bus.alu_result = bus.alu_a ^ bus.alu_b;
      5'b00101: bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
      5'b00110: bus.alu_result = bus.alu_a | bus.alu_b;
      5'b00111: bus.alu_result = bus.alu_a & bus.alu_b;
      5'b01000: bus.alu_result = bus.alu_a - bus.alu_b;
      5'b01101: bus.alu_result = alu_sa >>> bus.alu_b[4:0];
      default:  bus.alu_result = 32'd0;
    endcase
  end

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sel);
    bus.req_valid[i]        = v;
    bus.req_a[32*i +: 32]   = a;
    bus.req_b[32*i +: 32]   = b;
    bus.req_sel[5*i +: 5]   = sel;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Continuous protocol checks, sampled on the falling edge.
  logic        hold;
  logic [31:0] prev_res;
  logic [IDW-1:0] prev_id;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      chk("mon_onehot", {31'd0, $onehot0(bus.req_ready)}, 32'd1);
      chk("mon_rdy_implies_vld", {30'd0, bus.req_ready & ~bus.req_valid}, 32'd0);
      if (hold) begin
        chk("mon_hold_valid", {31'd0, bus.resp_valid}, 32'd1);
        chk("mon_hold_res", bus.resp_result, prev_res);
        chk("mon_hold_id", {30'd0, bus.resp_id}, {30'd0, prev_id});
      end
      hold     = bus.resp_valid && !bus.resp_ready;
      prev_res = bus.resp_result;
      prev_id  = bus.resp_id;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  int          exp_id  [4] = '{0, 1, 0, 1};
  logic [31:0] exp_res [4] = '{32'd2, 32'd7, 32'd2, 32'd7};
  logic [1:0]  exp_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

  initial begin
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_sel    = '0;
    bus.resp_ready = 1'b0;

    // Reset state, with a request already pending.
    set_req(0, 1'b1, 32'd5, 32'd7, 5'b00000);
    #2;
    chk("rst_valid",   {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_id",      {30'd0, bus.resp_id}, 32'd0);
    chk("rst_result",  bus.resp_result, 32'd0);
    chk("rst_ready",   {30'd0, bus.req_ready}, 32'd0);
    chk("rst_alu_a",   bus.alu_a, 32'd0);
    chk("rst_alu_b",   bus.alu_b, 32'd0);

    // Single op: 5 + 7.
    tick();
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", {30'd0, bus.req_ready}, 32'd1);
    chk("single_alu_a", bus.alu_a, 32'd5);
    chk("single_alu_b", bus.alu_b, 32'd7);
    tick();
    set_req(0, 1'b0, 32'd0, 32'd0, 5'b00000);
    @(negedge clk);
    chk("single_valid",  {31'd0, bus.resp_valid}, 32'd1);
    chk("single_id",     {30'd0, bus.resp_id}, 32'd0);
    chk("single_result", bus.resp_result, 32'd12);
    tick();
    @(negedge clk);
    chk("single_drain", {31'd0, bus.resp_valid}, 32'd0);

    // Round-robin from a fresh pointer.
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    set_req(0, 1'b1, 32'd1, 32'd1, 5'b00000);
    set_req(1, 1'b1, 32'd10, 32'd3, 5'b01000);
    #1;
    chk("rr_first_ready", {30'd0, bus.req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rr_valid",  {31'd0, bus.resp_valid}, 32'd1);
      chk("rr_id",     {30'd0, bus.resp_id}, exp_id[k]);
      chk("rr_result", bus.resp_result, exp_res[k]);
      chk("rr_ready",  {30'd0, bus.req_ready}, {30'd0, exp_rdy[k]});
    end
    #1;
    set_req(0, 1'b0, 32'd0, 32'd0, 5'b00000);
    set_req(1, 1'b0, 32'd0, 32'd0, 5'b00000);
    tick();
    @(negedge clk);
    chk("rr_drain", {31'd0, bus.resp_valid}, 32'd0);

    // Backpressure: accept req0, then stall the consumer.
    #1;
    set_req(0, 1'b1, 32'd5, 32'd7, 5'b00000);
    set_req(1, 1'b1, 32'd10, 32'd3, 5'b01000);
    #1;
    chk("bp_first_ready", {30'd0, bus.req_ready}, 32'd1);
    tick();
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("bp_hold_id",    {30'd0, bus.resp_id}, 32'd0);
      chk("bp_hold_res",   bus.resp_result, 32'd12);
      chk("bp_hold_ready", {30'd0, bus.req_ready}, 32'd0);
    end
    tick();
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {30'd0, bus.req_ready}, 32'd2);
    chk("bp_release_alu_a", bus.alu_a, 32'd10);
    tick();
    set_req(0, 1'b0, 32'd0, 32'd0, 5'b00000);
    set_req(1, 1'b0, 32'd0, 32'd0, 5'b00000);
    @(negedge clk);
    chk("bp_next_id",  {30'd0, bus.resp_id}, 32'd1);
    chk("bp_next_res", bus.resp_result, 32'd7);

    // Back-to-back from req1 while draining: srai then sltu.
    #1;
    set_req(1, 1'b1, 32'h8000_0000, 32'd4, 5'b01101);
    #1;
    chk("b2b_ready0", {30'd0, bus.req_ready}, 32'd2);
    chk("b2b_sel",    {27'd0, bus.alu_sel}, 32'd13);
    tick();
    set_req(1, 1'b1, 32'd1, 32'd2, 5'b00011);
    @(negedge clk);
    chk("b2b_res0",   bus.resp_result, 32'hF800_0000);
    chk("b2b_id0",    {30'd0, bus.resp_id}, 32'd1);
    chk("b2b_ready1", {30'd0, bus.req_ready}, 32'd2);
    tick();
    set_req(1, 1'b0, 32'd0, 32'd0, 5'b00000);
    @(negedge clk);
    chk("b2b_valid1", {31'd0, bus.resp_valid}, 32'd1);
    chk("b2b_res1",   bus.resp_result, 32'd1);

    // Illegal select yields 0 and still advances the pointer.
    #1;
    set_req(0, 1'b1, 32'd3, 32'd4, 5'b01010);
    #1;
    chk("ill_ready", {30'd0, bus.req_ready}, 32'd1);
    tick();
    set_req(0, 1'b0, 32'd0, 32'd0, 5'b00000);
    @(negedge clk);
    chk("ill_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("ill_id",    {30'd0, bus.resp_id}, 32'd0);
    chk("ill_res",   bus.resp_result, 32'd0);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("idle_valid", {31'd0, bus.resp_valid}, 32'd0);
    #1;
    set_req(0, 1'b1, 32'd3, 32'd4, 5'b01010);
    set_req(1, 1'b1, 32'd10, 32'd3, 5'b01000);
    #1;
    chk("ptr_after_idle", {30'd0, bus.req_ready}, 32'd2);
    tick();
    set_req(1, 1'b0, 32'd0, 32'd0, 5'b00000);
    set_req(0, 1'b1, 32'd20, 32'd22, 5'b00000);
    @(negedge clk);
    chk("pre_rst_res",   bus.resp_result, 32'd7);
    chk("pre_rst_ready", {30'd0, bus.req_ready}, 32'd1);
    tick();
    bus.resp_ready = 1'b0;
    set_req(0, 1'b0, 32'd0, 32'd0, 5'b00000);
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("pre_rst_42",    bus.resp_result, 32'd42);
    @(posedge clk);
    @(negedge clk);

    // Reset mid-operation with a stalled response (pointer was 1).
    #1 rst_n = 1'b0;
    #1;
    chk("rstm_valid",  {31'd0, bus.resp_valid}, 32'd0);
    chk("rstm_result", bus.resp_result, 32'd0);
    chk("rstm_id",     {30'd0, bus.resp_id}, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    set_req(0, 1'b1, 32'd1, 32'd1, 5'b00000);
    set_req(1, 1'b1, 32'd10, 32'd3, 5'b01000);
    #1;
    chk("rstm_ptr_zero", {30'd0, bus.req_ready}, 32'd1);
    set_req(0, 1'b0, 32'd0, 32'd0, 5'b00000);
    #1;
    chk("rstm_req1_ready", {30'd0, bus.req_ready}, 32'd2);
    tick();
    set_req(1, 1'b0, 32'd0, 32'd0, 5'b00000);
    @(negedge clk);
    chk("rstm_after_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("rstm_after_id",    {30'd0, bus.resp_id}, 32'd1);
    chk("rstm_after_res",   bus.resp_result, 32'd7);

    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
